// File: rtl/buf_pkg.sv
// Shared types for the multi-bank stream buffer: instruction format, opcodes,
// vector modes and FSM states.
package buf_pkg;

    localparam int BUF_DEPTH  = 256;
    localparam int BUF_AW     = $clog2(BUF_DEPTH);
    localparam int BUF_VEC_DW = 128;
    localparam int BUF_ELEM_W = 16;
    localparam int BUF_LANES  = BUF_VEC_DW / BUF_ELEM_W;
    localparam int BUF_LANE_W = $clog2(BUF_LANES);
    localparam int BUF_BW     = BUF_AW + BUF_LANE_W;
    localparam int BUF_LEN_W  = 4;

    typedef enum logic [1:0] {
        BUF_NOP   = 2'd0,
        BUF_READ  = 2'd1,
        BUF_WRITE = 2'd2
    } buf_op_e;

    typedef enum logic {
        VEC_MODE_FULL  = 1'b0,
        VEC_MODE_BCAST = 1'b1
    } vec_mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } buf_state_e;

    // memb_offset is an element address: word index in the upper bits, lane below.
    typedef struct packed {
        buf_op_e               opcode;
        vec_mode_e             mode;
        logic [BUF_AW-1:0]     mema_offset;
        logic [BUF_BW-1:0]     memb_offset;
        logic [BUF_LEN_W-1:0]  len_m1;
    } buf_inst_t;

endpackage

// File: rtl/stream_buf_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module stream_buf_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/multi_bank_stream_buffer.sv
// Burst-oriented matrix/vector/output buffer between controller and PE array.
// Optional BUF_PERF_CNT_EN adds saturating read/write/stall counters.
module multi_bank_stream_buffer
    import buf_pkg::*;
#(
    parameter int MAT_DW     = 128,
    parameter int VEC_DW     = BUF_VEC_DW,
    parameter int ELEM_W     = BUF_ELEM_W,
    parameter int OUT_DW     = 128,
    parameter int DEPTH      = BUF_DEPTH,
    parameter int LEN_W      = BUF_LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  buf_inst_t         buf_inst,
    input  logic              buf_inst_valid,
    output logic              buf_inst_ready,
    output logic [MAT_DW-1:0] matrix_data,
    output logic [VEC_DW-1:0] vector_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [OUT_DW-1:0] output_data,
    input  logic              output_valid,
    output logic              output_ready
`ifdef BUF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_rd_beats,
    output logic [31:0]       perf_wr_beats,
    output logic [31:0]       perf_stall
`endif
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LANES  = VEC_DW / ELEM_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = LEN_W + 1;
    localparam int FW     = MAT_DW + VEC_DW;
    localparam int FCW    = $clog2(FIFO_DEPTH + 1);

    logic [MAT_DW-1:0] mat_mem [DEPTH];
    logic [VEC_DW-1:0] vec_mem [DEPTH];
    logic [OUT_DW-1:0] out_mem [DEPTH];

    buf_state_e        state_q, state_d;
    logic [AW-1:0]     mema_q, mema_d;
    logic [BUF_BW-1:0] memb_q, memb_d;
    logic [LEN_W-1:0]  len_q, len_d;
    vec_mode_e         vmode_q, vmode_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              in_flight_q;

    logic              rd_issue, out_we, last_beat, credit_ok;
    logic [AW-1:0]     mat_addr, vec_addr;
    logic [FCW:0]      credit_used;

    logic [MAT_DW-1:0] mat_rd_q;
    logic [VEC_DW-1:0] vec_rd_q;
    vec_mode_e         rd_mode_q;
    logic [LANE_W-1:0] rd_lane_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_valid;
    logic [FW-1:0]     fifo_din, fifo_dout;
    logic [FCW-1:0]    fifo_count;

    function automatic logic [VEC_DW-1:0] vec_decode(input logic [VEC_DW-1:0] word,
                                                     input vec_mode_e         mode,
                                                     input logic [LANE_W-1:0] lane);
        logic [ELEM_W-1:0] elem;
        elem = word[int'(lane)*ELEM_W +: ELEM_W];
        return (mode == VEC_MODE_BCAST) ? {LANES{elem}} : word;
    endfunction

    assign mat_addr  = mema_q + AW'(beat_q);
    assign vec_addr  = AW'(memb_q >> LANE_W) + AW'(beat_q);
    assign last_beat = (beat_q == CNT_W'(len_q));

    // A beat in the memory stage is already committed to a FIFO slot, so it
    // counts against the credit alongside the FIFO occupancy.
    assign credit_used = {1'b0, fifo_count} + (FCW+1)'(in_flight_q);
    assign credit_ok   = (credit_used < (FCW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d        = state_q;
        mema_d         = mema_q;
        memb_d         = memb_q;
        len_d          = len_q;
        vmode_d        = vmode_q;
        beat_d         = beat_q;
        buf_inst_ready = 1'b0;
        output_ready   = 1'b0;
        rd_issue       = 1'b0;
        out_we         = 1'b0;
        case (state_q)
            IDLE: begin
                buf_inst_ready = 1'b1;
                if (buf_inst_valid) begin
                    mema_d  = AW'(buf_inst.mema_offset);
                    memb_d  = buf_inst.memb_offset;
                    len_d   = LEN_W'(buf_inst.len_m1);
                    vmode_d = buf_inst.mode;
                    beat_d  = '0;
                    if (buf_inst.opcode == BUF_READ)       state_d = RD_BURST;
                    else if (buf_inst.opcode == BUF_WRITE) state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                if (credit_ok) begin
                    rd_issue = 1'b1;
                    if (last_beat) state_d = IDLE;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            WR_BURST: begin
                output_ready = 1'b1;
                if (output_valid) begin
                    out_we = 1'b1;
                    if (last_beat) state_d = IDLE;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mema_q      <= '0;
            memb_q      <= '0;
            len_q       <= '0;
            vmode_q     <= VEC_MODE_FULL;
            beat_q      <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mema_q      <= mema_d;
            memb_q      <= memb_d;
            len_q       <= len_d;
            vmode_q     <= vmode_d;
            beat_q      <= beat_d;
            in_flight_q <= rd_issue;
        end
    end

    // Mode and lane travel with each read so a following instruction cannot
    // alter the decode of beats still in the pipeline.
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            mat_rd_q  <= mat_mem[mat_addr];
            vec_rd_q  <= vec_mem[vec_addr];
            rd_mode_q <= vmode_q;
            rd_lane_q <= memb_q[LANE_W-1:0];
        end
        if (out_we) out_mem[mat_addr] <= output_data;
    end

    assign fifo_push = in_flight_q;
    assign fifo_din  = {mat_rd_q, vec_decode(vec_rd_q, rd_mode_q, rd_lane_q)};
    assign fifo_pop  = rd_ready;

    stream_buf_fifo #(
        .DW    (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign rd_valid    = fifo_valid;
    assign matrix_data = fifo_valid ? fifo_dout[FW-1:VEC_DW] : '0;
    assign vector_data = fifo_valid ? fifo_dout[VEC_DW-1:0]  : '0;

`ifdef BUF_PERF_CNT_EN
    logic [31:0] rd_beats_q, wr_beats_q, stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        return (en && (val != '1)) ? val + 32'd1 : val;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_beats_q <= '0;
            wr_beats_q <= '0;
            stall_q    <= '0;
        end else begin
            rd_beats_q <= sat_inc(rd_beats_q, rd_valid && rd_ready);
            wr_beats_q <= sat_inc(wr_beats_q, out_we);
            stall_q    <= sat_inc(stall_q, rd_valid && !rd_ready);
        end
    end

    assign perf_rd_beats = rd_beats_q;
    assign perf_wr_beats = wr_beats_q;
    assign perf_stall    = stall_q;
`endif

endmodule

// File: tb/tb_multi_bank_stream_buffer.sv
// Scoreboard bench for multi_bank_stream_buffer: read bursts, backpressure,
// address wrap, write bursts, broadcast decode and mid-burst reset.
module tb_multi_bank_stream_buffer;
    import buf_pkg::*;

    localparam int DEPTH  = 256;
    localparam int MAT_DW = 128;
    localparam int VEC_DW = 128;
    localparam int ELEM_W = 16;
    localparam int OUT_DW = 128;
    localparam int LANES  = VEC_DW / ELEM_W;
    localparam int LANE_W = 3;

    typedef struct packed {
        logic [MAT_DW-1:0] mat;
        logic [VEC_DW-1:0] vec;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    buf_inst_t         buf_inst;
    logic              buf_inst_valid;
    logic              buf_inst_ready;
    logic [MAT_DW-1:0] matrix_data;
    logic [VEC_DW-1:0] vector_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [OUT_DW-1:0] output_data;
    logic              output_valid;
    logic              output_ready;
`ifdef BUF_PERF_CNT_EN
    logic [31:0]       perf_rd_beats, perf_wr_beats, perf_stall;
`endif

    beat_t             sb_q[$];
    int                n_chk  = 0;
    int                n_fail = 0;
    int                rdy_mode = 0;
    logic [MAT_DW-1:0] mat_mdl [DEPTH];
    logic [VEC_DW-1:0] vec_mdl [DEPTH];
    int                wr_pat [4] = '{1, 0, 1, 1};
    logic [OUT_DW-1:0] wr_words [4];

    always #5 clk = ~clk;

    multi_bank_stream_buffer #(
        .MAT_DW(MAT_DW), .VEC_DW(VEC_DW), .ELEM_W(ELEM_W), .OUT_DW(OUT_DW),
        .DEPTH(DEPTH), .LEN_W(4), .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .buf_inst       (buf_inst),
        .buf_inst_valid (buf_inst_valid),
        .buf_inst_ready (buf_inst_ready),
        .matrix_data    (matrix_data),
        .vector_data    (vector_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .output_data    (output_data),
        .output_valid   (output_valid),
        .output_ready   (output_ready)
`ifdef BUF_PERF_CNT_EN
        ,
        .perf_rd_beats  (perf_rd_beats),
        .perf_wr_beats  (perf_wr_beats),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VEC_DW-1:0] mdl_vec(input logic [VEC_DW-1:0] w, input logic mode, input int lane);
        logic [VEC_DW-1:0] r;
        r = w;
        if (mode)
            for (int i = 0; i < LANES; i++) r[i*ELEM_W +: ELEM_W] = w[lane*ELEM_W +: ELEM_W];
        return r;
    endfunction

    function automatic buf_inst_t mk_inst(input buf_op_e op, input logic mode, input int mema,
                                          input int memb, input int len_m1);
        buf_inst_t i;
        i.opcode      = op;
        i.mode        = vec_mode_e'(mode);
        i.mema_offset = mema[BUF_AW-1:0];
        i.memb_offset = memb[BUF_BW-1:0];
        i.len_m1      = len_m1[BUF_LEN_W-1:0];
        return i;
    endfunction

    task automatic exp_read(input int mema, input int memb, input int len_m1, input logic mode);
        for (int b = 0; b <= len_m1; b++) begin
            beat_t e;
            e.mat = mat_mdl[(mema + b) % DEPTH];
            e.vec = mdl_vec(vec_mdl[((memb >> LANE_W) + b) % DEPTH], mode, memb % LANES);
            sb_q.push_back(e);
        end
    endtask

    task automatic send_inst(input buf_inst_t inst);
        int n = 0;
        @(posedge clk); #1;
        buf_inst       = inst;
        buf_inst_valid = 1'b1;
        @(negedge clk);
        while (!buf_inst_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("inst_accept_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
        buf_inst_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_done", 256'(sb_q.size()), 256'd0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && dut.fifo_push)
            check_val("fifo_overflow", {255'b0, dut.fifo_full && !dut.fifo_pop}, 256'd0);
        if (rst_n && rd_valid) begin
            if (sb_q.size() == 0) begin
                check_val("rd_unexpected_beat", 256'd1, 256'd0);
            end else if (rd_ready) begin
                e = sb_q.pop_front();
                check_val("rd_mat", matrix_data, e.mat);
                check_val("rd_vec", vector_data, e.vec);
            end else begin
                check_val("hold_mat", matrix_data, sb_q[0].mat);
                check_val("hold_vec", vector_data, sb_q[0].vec);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        buf_inst       = '0;
        buf_inst_valid = 1'b0;
        output_data    = '0;
        output_valid   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mat_mdl[i] = {$urandom(), $urandom(), $urandom(), 32'(i)};
            vec_mdl[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        vec_mdl[5] = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        for (int i = 0; i < DEPTH; i++) begin
            dut.mat_mem[i] = mat_mdl[i];
            dut.vec_mem[i] = vec_mdl[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_inst_ready", {255'b0, buf_inst_ready}, 256'd1);
        check_val("rst_rd_valid", {255'b0, rd_valid}, 256'd0);
        check_val("rst_output_ready", {255'b0, output_ready}, 256'd0);
        check_val("rst_matrix_data", matrix_data, 256'd0);
        check_val("rst_vector_data", vector_data, 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic burst: latency and early acceptance of the next instruction
        rdy_mode = 1;
        @(posedge clk);
        exp_read(0, 0, 3, 1'b0);
        send_inst(mk_inst(BUF_READ, 1'b0, 0, 0, 3));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val($sformatf("lat_rd_valid_%0d", k), {255'b0, rd_valid}, 256'(k >= 2));
            check_val($sformatf("lat_inst_ready_%0d", k), {255'b0, buf_inst_ready}, 256'(k >= 4));
        end
        wait_drain(20);

        // Unused opcodes are consumed without leaving IDLE
        send_inst(mk_inst(BUF_NOP, 1'b0, 0, 0, 5));
        @(negedge clk);
        check_val("nop_inst_ready", {255'b0, buf_inst_ready}, 256'd1);
        check_val("nop_output_ready", {255'b0, output_ready}, 256'd0);
        send_inst(mk_inst(buf_op_e'(2'd3), 1'b0, 0, 0, 5));
        @(negedge clk);
        check_val("op3_inst_ready", {255'b0, buf_inst_ready}, 256'd1);
        check_val("op3_rd_valid", {255'b0, rd_valid}, 256'd0);

        // Backpressure: credit limits buffered beats to the FIFO depth
        rdy_mode = 0;
        @(posedge clk);
        exp_read(20, 20 << LANE_W, 7, 1'b0);
        send_inst(mk_inst(BUF_READ, 1'b0, 20, 20 << LANE_W, 7));
        repeat (12) @(negedge clk);
        check_val("stall_fifo_count", 256'(dut.fifo_count), 256'd4);
        check_val("stall_busy", {255'b0, buf_inst_ready}, 256'd0);
        check_val("stall_rd_valid", {255'b0, rd_valid}, 256'd1);
        rdy_mode = 1;
        wait_drain(100);
        @(negedge clk);
        check_val("stall_done_ready", {255'b0, buf_inst_ready}, 256'd1);

        // Address wrap, with broadcast of lane 1 under random backpressure
        rdy_mode = 2;
        exp_read(DEPTH - 2, ((DEPTH - 2) << LANE_W) | 1, 3, 1'b1);
        send_inst(mk_inst(BUF_READ, 1'b1, DEPTH - 2, ((DEPTH - 2) << LANE_W) | 1, 3));
        wait_drain(200);

        // Write burst with a gap in output_valid
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) wr_words[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_inst(mk_inst(BUF_WRITE, 1'b0, 10, 0, 2));
        for (int k = 0; k < 4; k++) begin
            output_valid = 1'(wr_pat[k]);
            output_data  = wr_words[k];
            @(negedge clk);
            check_val($sformatf("wr_output_ready_%0d", k), {255'b0, output_ready}, 256'd1);
            @(posedge clk); #1;
        end
        output_valid = 1'b0;
        @(negedge clk);
        check_val("wr_done_output_ready", {255'b0, output_ready}, 256'd0);
        check_val("wr_done_inst_ready", {255'b0, buf_inst_ready}, 256'd1);
        check_val("wr_mem10", dut.out_mem[10], wr_words[0]);
        check_val("wr_mem11", dut.out_mem[11], wr_words[2]);
        check_val("wr_mem12", dut.out_mem[12], wr_words[3]);

        // Broadcast of element 3 from a known word
        begin
            beat_t e;
            e.mat = mat_mdl[7];
            e.vec = {8{16'h0004}};
            sb_q.push_back(e);
        end
        send_inst(mk_inst(BUF_READ, 1'b1, 7, (5 << LANE_W) | 3, 0));
        wait_drain(20);

        // Back-to-back random bursts under random backpressure
        rdy_mode = 2;
        for (int n = 0; n < 6; n++) begin
            int   ma, mb, ln;
            logic md;
            ma = int'($urandom_range(0, DEPTH - 1));
            mb = int'($urandom_range(0, (DEPTH << LANE_W) - 1));
            ln = int'($urandom_range(0, 15));
            md = 1'($urandom_range(0, 1));
            exp_read(ma, mb, ln, md);
            send_inst(mk_inst(BUF_READ, md, ma, mb, ln));
        end
        wait_drain(600);

        // Reset in the middle of a stalled read burst
        rdy_mode = 0;
        @(posedge clk);
        exp_read(40, 40 << LANE_W, 15, 1'b0);
        send_inst(mk_inst(BUF_READ, 1'b0, 40, 40 << LANE_W, 15));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_val("mid_rst_rd_valid", {255'b0, rd_valid}, 256'd0);
        check_val("mid_rst_inst_ready", {255'b0, buf_inst_ready}, 256'd1);
        check_val("mid_rst_fifo_count", 256'(dut.fifo_count), 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 1;
        exp_read(100, 3 << LANE_W, 2, 1'b0);
        send_inst(mk_inst(BUF_READ, 1'b0, 100, 3 << LANE_W, 2));
        wait_drain(50);

        repeat (5) @(negedge clk);
        check_val("sb_empty_end", 256'(sb_q.size()), 256'd0);
        check_val("end_rd_valid", {255'b0, rd_valid}, 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
